// File: rtl/rfphoenix_dcache_wrq_pkg.sv
// Shared types and default geometry for the dcache store-hit write queue.
package rfphoenix_dcache_wrq_pkg;

  localparam int DCWQ_NWAYS  = 4;
  localparam int DCWQ_NBANKS = 2;
  localparam int DCWQ_LINEW  = 512;
  localparam int DCWQ_AWID   = 32;
  localparam int DCWQ_QDEPTH = 4;

  typedef enum logic [1:0] {
    DCWQ_IDLE  = 2'd0,
    DCWQ_ISSUE = 2'd1,
    DCWQ_FILL  = 2'd2
  } dcwq_state_t;

endpackage

// File: rtl/rfphoenix_dcache_bankstrb.sv
// Reduces line-aligned byte enables to one write strobe per data RAM bank.
module rfphoenix_dcache_bankstrb
  import rfphoenix_dcache_wrq_pkg::*;
#(
  parameter int NBANKS = DCWQ_NBANKS,
  parameter int LINEW  = DCWQ_LINEW
) (
  input  logic [LINEW/8-1:0] sel,
  output logic [NBANKS-1:0]  wr
);

  localparam int BANKB = LINEW / 8 / NBANKS;

  // OR-reduce each bank's byte-enable slice
  always_comb begin
    wr = {NBANKS{1'b0}};
    for (int b = 0; b < NBANKS; b++) begin
      wr[b] = |sel[b*BANKB +: BANKB];
    end
  end

endmodule

// File: rtl/rfphoenix_dcache_wrq.sv
// Ordered store-hit write queue for the dcache data RAMs; line fills pre-empt
// queued stores, and an empty queue forwards a store straight to the RAM port.
module rfphoenix_dcache_wrq
  import rfphoenix_dcache_wrq_pkg::*;
#(
  parameter int NWAYS  = DCWQ_NWAYS,
  parameter int NBANKS = DCWQ_NBANKS,
  parameter int LINEW  = DCWQ_LINEW,
  parameter int AWID   = DCWQ_AWID,
  parameter int QDEPTH = DCWQ_QDEPTH
) (
  input  logic                        rst,
  input  logic                        clk,
  input  logic                        st_req,
  output logic                        st_rdy,
  input  logic [AWID-1:0]             st_adr,
  input  logic [LINEW-1:0]            st_dat,
  input  logic [LINEW/8-1:0]          st_sel,
  input  logic [NWAYS-1:0]            st_hit,
  input  logic                        st_cache,
  input  logic                        fill_req,
  input  logic [NWAYS-1:0]            fill_way,
  input  logic [AWID-1:0]             fill_adr,
  input  logic [LINEW-1:0]            fill_dat,
  input  logic                        inv_req,
  input  logic [AWID-1:0]             inv_adr,
  output logic [NBANKS-1:0]           wr,
  output logic [NWAYS-1:0]            wway,
  output logic [AWID-1:0]             wadr,
  output logic [LINEW-1:0]            wdat,
  output logic [LINEW/8-1:0]          wsel,
  output logic [$clog2(QDEPTH):0]     qcount
);

  localparam int SELW = LINEW / 8;
  localparam int OFFW = $clog2(SELW);
  localparam int PTRW = $clog2(QDEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [AWID-1:0] LMASK = {{(AWID-OFFW){1'b1}}, {OFFW{1'b0}}};

  typedef struct packed {
    logic             v;
    logic [AWID-1:0]  adr;
    logic [NWAYS-1:0] way;
    logic [LINEW-1:0] dat;
    logic [SELW-1:0]  sel;
  } dcwq_entry_t;

  function automatic logic line_eq(input logic [AWID-1:0] a, input logic [AWID-1:0] b);
    return ((a ^ b) & LMASK) == {AWID{1'b0}};
  endfunction

  dcwq_entry_t     q_r [QDEPTH];
  logic [PTRW-1:0] head_r;
  logic [PTRW-1:0] tail_r;
  logic [CNTW-1:0] count_r;
  dcwq_state_t     state_r;

  dcwq_entry_t     head_s;
  dcwq_entry_t     tail_s;
  dcwq_entry_t     push_entry_s;
  logic [PTRW-1:0] tail_idx_s;
  logic [CNTW-1:0] count_next_s;
  logic [LINEW-1:0] merge_dat_s;
  logic [NBANKS-1:0] head_wr_s;
  logic [NBANKS-1:0] st_wr_s;
  logic full_s, issue_s, head_live_s, accept_s, elig_s, bypass_s, merge_s, push_s;

  rfphoenix_dcache_bankstrb #(.NBANKS(NBANKS), .LINEW(LINEW)) u_head_strb (
    .sel (head_s.sel),
    .wr  (head_wr_s)
  );

  rfphoenix_dcache_bankstrb #(.NBANKS(NBANKS), .LINEW(LINEW)) u_st_strb (
    .sel (st_sel),
    .wr  (st_wr_s)
  );

  // Queue control: accept/drop, bypass, tail merge, push and head issue decisions
  always_comb begin
    head_s      = q_r[head_r];
    tail_idx_s  = tail_r - PTRW'(1);
    tail_s      = q_r[tail_idx_s];
    full_s      = (count_r == CNTW'(QDEPTH));
    issue_s     = (state_r != DCWQ_IDLE) && (count_r != CNTW'(0)) && !fill_req;
    head_live_s = head_s.v && !(inv_req && line_eq(inv_adr, head_s.adr));
    st_rdy      = !full_s || issue_s;
    accept_s    = st_req && st_rdy;
    // A store racing an invalidate of its own line is dropped
    elig_s      = accept_s && st_cache && (|st_hit) && !(inv_req && line_eq(inv_adr, st_adr));
    bypass_s    = elig_s && (count_r == CNTW'(0)) && !fill_req;
    merge_s     = elig_s && !bypass_s && (count_r != CNTW'(0)) && tail_s.v &&
                  line_eq(tail_s.adr, st_adr) && (tail_s.way == st_hit) &&
                  !(issue_s && (count_r == CNTW'(1)));
    push_s      = elig_s && !bypass_s && !merge_s;
    merge_dat_s = tail_s.dat;
    for (int i = 0; i < SELW; i++) begin
      if (st_sel[i]) begin
        merge_dat_s[i*8 +: 8] = st_dat[i*8 +: 8];
      end else begin
        merge_dat_s[i*8 +: 8] = tail_s.dat[i*8 +: 8];
      end
    end
    push_entry_s = '{v: 1'b1, adr: st_adr, way: st_hit, dat: st_dat, sel: st_sel};
    count_next_s = count_r + CNTW'(push_s) - CNTW'(issue_s);
  end

  // Queue storage, pointers, state and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= '{default: '0};
      head_r  <= PTRW'(0);
      tail_r  <= PTRW'(0);
      count_r <= CNTW'(0);
      state_r <= DCWQ_IDLE;
      wr      <= {NBANKS{1'b0}};
      wway    <= {NWAYS{1'b0}};
      wadr    <= {AWID{1'b0}};
      wdat    <= {LINEW{1'b0}};
      wsel    <= {SELW{1'b0}};
      qcount  <= CNTW'(0);
    end else begin
      if (fill_req) begin
        wr   <= {NBANKS{1'b1}};
        wway <= fill_way;
        wadr <= fill_adr & LMASK;
        wdat <= fill_dat;
        wsel <= {SELW{1'b1}};
      end else if (issue_s && head_live_s) begin
        wr   <= head_wr_s;
        wway <= head_s.way;
        wadr <= head_s.adr & LMASK;
        wdat <= head_s.dat;
        wsel <= head_s.sel;
      end else if (bypass_s) begin
        wr   <= st_wr_s;
        wway <= st_hit;
        wadr <= st_adr & LMASK;
        wdat <= st_dat;
        wsel <= st_sel;
      end else begin
        wr   <= {NBANKS{1'b0}};
        wway <= {NWAYS{1'b0}};
        wadr <= {AWID{1'b0}};
        wdat <= {LINEW{1'b0}};
        wsel <= {SELW{1'b0}};
      end

      for (int i = 0; i < QDEPTH; i++) begin
        if (inv_req && line_eq(inv_adr, q_r[i].adr)) begin
          q_r[i].v <= 1'b0;
        end
      end
      if (push_s) begin
        q_r[tail_r] <= push_entry_s;
        tail_r      <= tail_r + PTRW'(1);
      end
      if (merge_s) begin
        q_r[tail_idx_s].dat <= merge_dat_s;
        q_r[tail_idx_s].sel <= tail_s.sel | st_sel;
      end
      if (issue_s) begin
        head_r <= head_r + PTRW'(1);
      end

      count_r <= count_next_s;
      qcount  <= count_next_s;
      case (1'b1)
        fill_req:                      state_r <= DCWQ_FILL;
        (count_next_s != CNTW'(0)):    state_r <= DCWQ_ISSUE;
        default:                       state_r <= DCWQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfphoenix_dcache_wrq.sv
// Directed table-driven bench for the dcache store-hit write queue.
module tb_rfphoenix_dcache_wrq;

  logic         rst, clk;
  logic         st_req, st_rdy, st_cache, fill_req, inv_req;
  logic [31:0]  st_adr, fill_adr, inv_adr, wadr;
  logic [511:0] st_dat, fill_dat, wdat;
  logic [63:0]  st_sel, wsel;
  logic [3:0]   st_hit, fill_way, wway;
  logic [1:0]   wr;
  logic [2:0]   qcount;

  int checks = 0;
  int failures = 0;

  rfphoenix_dcache_wrq dut (
    .rst(rst), .clk(clk),
    .st_req(st_req), .st_rdy(st_rdy), .st_adr(st_adr), .st_dat(st_dat),
    .st_sel(st_sel), .st_hit(st_hit), .st_cache(st_cache),
    .fill_req(fill_req), .fill_way(fill_way), .fill_adr(fill_adr), .fill_dat(fill_dat),
    .inv_req(inv_req), .inv_adr(inv_adr),
    .wr(wr), .wway(wway), .wadr(wadr), .wdat(wdat), .wsel(wsel), .qcount(qcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        cache;
    logic [3:0]  hit;
    logic [31:0] adr;
    logic [63:0] sel;
    logic [7:0]  byt;
    logic        fill;
    logic [3:0]  fway;
    logic [31:0] fadr;
    logic        inv;
    logic [31:0] iadr;
    logic        e_rdy;
    logic [1:0]  e_wr;
    logic [3:0]  e_wway;
    logic [31:0] e_wadr;
    logic [63:0] e_wsel;
    logic [2:0]  e_q;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] B32  = 64'h0000_0001_0000_0000;

  function automatic vec_t mk(
    input logic req, input logic cache, input logic [3:0] hit, input logic [31:0] adr,
    input logic [63:0] sel, input logic [7:0] byt,
    input logic fill, input logic [3:0] fway, input logic [31:0] fadr,
    input logic inv, input logic [31:0] iadr,
    input logic e_rdy, input logic [1:0] e_wr, input logic [3:0] e_wway,
    input logic [31:0] e_wadr, input logic [63:0] e_wsel, input logic [2:0] e_q);
    return '{req, cache, hit, adr, sel, byt, fill, fway, fadr, inv, iadr,
             e_rdy, e_wr, e_wway, e_wadr, e_wsel, e_q};
  endfunction

  function automatic vec_t idle(input logic [2:0] q, input logic [1:0] e_wr,
                                input logic [3:0] e_wway, input logic [31:0] e_wadr,
                                input logic [63:0] e_wsel);
    return mk(1'b0, 1'b0, 4'h0, 32'h0, 64'h0, 8'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,
              1'b1, e_wr, e_wway, e_wadr, e_wsel, q);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    st_req   = v.req;  st_cache = v.cache; st_hit = v.hit; st_adr = v.adr;
    st_sel   = v.sel;  st_dat   = {64{v.byt}};
    fill_req = v.fill; fill_way = v.fway;  fill_adr = v.fadr; fill_dat = {64{8'hF0}};
    inv_req  = v.inv;  inv_adr  = v.iadr;
  endtask

  vec_t tbl [26];
  vec_t nil;
  logic [511:0] d2;

  initial begin
    nil = idle(3'd0, 2'b00, 4'h0, 32'h0, 64'h0);
    // single bypassed store, then dropped miss / uncacheable stores
    tbl[0]  = mk(1, 1, 4'b0010, 32'h1000, 64'hF, 8'h11, 0, 4'h0, 32'h0, 0, 32'h0, 1, 2'b01, 4'b0010, 32'h1000, 64'hF, 3'd0);
    tbl[1]  = idle(3'd0, 2'b00, 4'h0, 32'h0, 64'h0);
    tbl[2]  = mk(1, 1, 4'b0000, 32'h1040, 64'hF, 8'h22, 0, 4'h0, 32'h0, 0, 32'h0, 1, 2'b00, 4'h0, 32'h0, 64'h0, 3'd0);
    tbl[3]  = mk(1, 0, 4'b0010, 32'h1080, 64'hF, 8'h33, 0, 4'h0, 32'h0, 0, 32'h0, 1, 2'b00, 4'h0, 32'h0, 64'h0, 3'd0);
    tbl[4]  = idle(3'd0, 2'b00, 4'h0, 32'h0, 64'h0);
    // six-cycle fill while five stores arrive; fifth sees a full queue
    tbl[5]  = mk(1, 1, 4'b0001, 32'h6000, 64'hF, 8'h41, 1, 4'b1000, 32'h8000, 0, 32'h0, 1, 2'b11, 4'b1000, 32'h8000, ONES, 3'd1);
    tbl[6]  = mk(1, 1, 4'b0001, 32'h6040, 64'hF, 8'h42, 1, 4'b1000, 32'h8000, 0, 32'h0, 1, 2'b11, 4'b1000, 32'h8000, ONES, 3'd2);
    tbl[7]  = mk(1, 1, 4'b0001, 32'h6080, B32,   8'h43, 1, 4'b1000, 32'h8000, 0, 32'h0, 1, 2'b11, 4'b1000, 32'h8000, ONES, 3'd3);
    tbl[8]  = mk(1, 1, 4'b0001, 32'h60C0, 64'hF, 8'h44, 1, 4'b1000, 32'h8000, 0, 32'h0, 1, 2'b11, 4'b1000, 32'h8000, ONES, 3'd4);
    tbl[9]  = mk(1, 1, 4'b0001, 32'h6100, 64'hF, 8'h45, 1, 4'b1000, 32'h8000, 0, 32'h0, 0, 2'b11, 4'b1000, 32'h8000, ONES, 3'd4);
    tbl[10] = mk(0, 0, 4'h0, 32'h0, 64'h0, 8'h0, 1, 4'b1000, 32'h8000, 0, 32'h0, 0, 2'b11, 4'b1000, 32'h8000, ONES, 3'd4);
    tbl[11] = idle(3'd3, 2'b01, 4'b0001, 32'h6000, 64'hF);
    tbl[12] = idle(3'd2, 2'b01, 4'b0001, 32'h6040, 64'hF);
    tbl[13] = idle(3'd1, 2'b10, 4'b0001, 32'h6080, B32);
    tbl[14] = idle(3'd0, 2'b01, 4'b0001, 32'h60C0, 64'hF);
    tbl[15] = idle(3'd0, 2'b00, 4'h0, 32'h0, 64'h0);
    // store and fill to the same line in one cycle: fill first
    tbl[16] = mk(1, 1, 4'b0100, 32'h3000, 64'hF, 8'h55, 1, 4'b0100, 32'h3000, 0, 32'h0, 1, 2'b11, 4'b0100, 32'h3000, ONES, 3'd1);
    tbl[17] = idle(3'd0, 2'b01, 4'b0100, 32'h3000, 64'hF);
    // invalidate one of two queued lines
    tbl[18] = mk(1, 1, 4'b0001, 32'h4000, 64'hF, 8'h66, 1, 4'b0001, 32'h9000, 0, 32'h0, 1, 2'b11, 4'b0001, 32'h9000, ONES, 3'd1);
    tbl[19] = mk(1, 1, 4'b0001, 32'h5000, 64'hF, 8'h77, 1, 4'b0001, 32'h9000, 0, 32'h0, 1, 2'b11, 4'b0001, 32'h9000, ONES, 3'd2);
    tbl[20] = mk(0, 0, 4'h0, 32'h0, 64'h0, 8'h0, 1, 4'b0001, 32'h9000, 1, 32'h4000, 1, 2'b11, 4'b0001, 32'h9000, ONES, 3'd2);
    tbl[21] = idle(3'd1, 2'b00, 4'h0, 32'h0, 64'h0);
    tbl[22] = idle(3'd0, 2'b01, 4'b0001, 32'h5000, 64'hF);
    tbl[23] = idle(3'd0, 2'b00, 4'h0, 32'h0, 64'h0);
    // store and invalidate of the same line together: store dropped
    tbl[24] = mk(1, 1, 4'b0001, 32'h7000, 64'hF, 8'h88, 0, 4'h0, 32'h0, 1, 32'h7000, 1, 2'b00, 4'h0, 32'h0, 64'h0, 3'd0);
    tbl[25] = idle(3'd0, 2'b00, 4'h0, 32'h0, 64'h0);

    rst = 1'b1;
    drive(nil);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_wr", 64'(wr), 64'h0);
    chk("reset_wway", 64'(wway), 64'h0);
    chk("reset_wadr", 64'(wadr), 64'h0);
    chk("reset_wsel", wsel, 64'h0);
    chk("reset_wdat_lo", wdat[63:0], 64'h0);
    chk("reset_qcount", 64'(qcount), 64'h0);
    chk("reset_st_rdy", 64'(st_rdy), 64'h1);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_st_rdy", i), 64'(st_rdy), 64'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_wr", i), 64'(wr), 64'(tbl[i].e_wr));
      chk($sformatf("row%0d_qcount", i), 64'(qcount), 64'(tbl[i].e_q));
      if (tbl[i].e_wr != 2'b00) begin
        chk($sformatf("row%0d_wway", i), 64'(wway), 64'(tbl[i].e_wway));
        chk($sformatf("row%0d_wadr", i), 64'(wadr), 64'(tbl[i].e_wadr));
        chk($sformatf("row%0d_wsel", i), wsel, tbl[i].e_wsel);
      end
    end

    // merge: two stores to line 0x2000 held behind a fill collapse into one strobe
    @(negedge clk);
    drive(mk(1, 1, 4'b0010, 32'h2000, 64'h1, 8'hAA, 1, 4'b0010, 32'hA000, 0, 32'h0, 1, 2'b00, 4'h0, 32'h0, 64'h0, 3'd0));
    @(posedge clk); #1;
    chk("merge_q_first", 64'(qcount), 64'd1);
    @(negedge clk);
    drive(mk(1, 1, 4'b0010, 32'h2000, 64'h0000_0001_0000_0001, 8'h00, 1, 4'b0010, 32'hA000, 0, 32'h0, 1, 2'b00, 4'h0, 32'h0, 64'h0, 3'd0));
    d2 = 512'h0;
    d2[7:0] = 8'hBB;
    d2[263:256] = 8'hCC;
    st_dat = d2;
    @(posedge clk); #1;
    chk("merge_q_second", 64'(qcount), 64'd1);
    @(negedge clk);
    drive(nil);
    @(posedge clk); #1;
    chk("merge_wr", 64'(wr), 64'h3);
    chk("merge_wway", 64'(wway), 64'h2);
    chk("merge_wadr", 64'(wadr), 64'h2000);
    chk("merge_byte0", 64'(wdat[7:0]), 64'hBB);
    chk("merge_byte1_old", 64'(wdat[15:8]), 64'hAA);
    chk("merge_byte32", 64'(wdat[263:256]), 64'hCC);
    chk("merge_wsel", wsel, 64'h0000_0001_0000_0001);
    chk("merge_q_drained", 64'(qcount), 64'd0);
    @(posedge clk); #1;
    chk("merge_single_strobe", 64'(wr), 64'h0);

    // asynchronous reset with two entries queued discards them
    @(negedge clk);
    drive(mk(1, 1, 4'b0001, 32'hC000, 64'hF, 8'h99, 1, 4'b0001, 32'hD000, 0, 32'h0, 1, 2'b00, 4'h0, 32'h0, 64'h0, 3'd0));
    @(negedge clk);
    st_adr = 32'hC040;
    @(posedge clk); #1;
    chk("rst_pre_qcount", 64'(qcount), 64'd2);
    @(negedge clk);
    drive(nil);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_qcount", 64'(qcount), 64'd0);
    chk("rst_async_wr", 64'(wr), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_post%0d_wr", k), 64'(wr), 64'h0);
      chk($sformatf("rst_post%0d_qcount", k), 64'(qcount), 64'd0);
    end
    chk("rst_post_st_rdy", 64'(st_rdy), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
